msk_shiftrows_iter: RTL and testbench
=====================================

// Module: msk_shiftrows_iter
// PURPOSE
//  Masked Skinny ShiftRows engine: applies ShiftRows^k or its inverse to a d-share
//  4x4 cell state, one permutation step per clock. Each share is permuted independently,
//  so there is no share mixing and no recombination.
//  Sits between state register and MixColumns in serialised/leveled Skinny datapaths.
//  Also serves key-schedule and decryption paths that need multi-step or inverse
//  row rotation.
// PARAMETERS
//  d   2  number of shares (>=1)
//  W   8  cell width in bits (8: Skinny-128, 4: Skinny-64)
//  KW  2  width of step-count input (k taken mod 2^KW)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous reset, active low
//  in_valid   in   1        input sharing valid
//  in_ready   out  1        block can accept a new state
//  in_state   in   16*d*W   masked state (layout below)
//  in_inv     in   1        0: forward ShiftRows, 1: inverse
//  in_k       in   KW       number of steps to apply
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_state  out  16*d*W   permuted masked state
// BEHAVIOUR
//  Layout: cell c (0..15, row-major, r=c/4, j=c%4) occupies [(16-c)*d*W-1:(15-c)*d*W].
//   Share s of a cell occupies bits [(s+1)*W-1:s*W] of that cell's slot.
//  Forward step: new[r][j]=old[r][(j-r) mod 4]. Inverse step: new[r][j]=old[r][(j+r) mod 4].
//   Each step applies the same cell move to every share.
//  Reset (async, rst_n=0): FSM=IDLE, data reg=0, cnt=0, inv reg=0, out_valid=0.
//   in_ready=0 while rst_n is low.
//  FSM:
//   IDLE: in_ready=1. On the edge with in_valid=1, capture in_state, in_inv and in_k.
//    If in_k==0, go to DONE; otherwise go to RUN with cnt=in_k.
//   RUN: on each edge apply one step with the latched direction and decrement cnt.
//    When cnt==1, go to DONE. in_ready=0; in_valid is ignored.
//   DONE: out_valid=1. out_state = data reg, held stable until out_ready=1.
//    On the edge with out_ready=1: data reg<=0 (no share residue), go to IDLE.
//  Latency: out_valid rises k+1 cycles after the accept edge; k=0 gives 1 cycle.
//   Throughput is one state per k+2 cycles, since accept is not allowed while in DONE.
//  out_state is driven only from the register. It is 0 in IDLE and RUN, and is not
//   qualified combinationally by out_valid.
//  in_inv and in_k may change freely after accept; the latched copies are used.
//  Reset mid-RUN or mid-DONE aborts: no out_valid, and the data reg is zeroed.
//  k wraps mod 2^KW. ShiftRows^4 is the identity, so KW>2 is legal; the result
//   equals k mod 4 steps.
//  Upstream must hold in_valid and in_state until in_ready is high (valid/ready rules).
// TESTING
//  d=2, W=8. Share0 of cell c = c; share1 of cell c = 8'h80|c.
//  1) fwd, k=1 -> share0 rows: 00 01 02 03 | 07 04 05 06 | 0A 0B 08 09 | 0D 0E 0F 0C.
//     Share1 shows the same cell order with bit7 set; out_valid 2 cycles after accept.
//  2) inv, k=1 -> share0 rows: 00 01 02 03 | 05 06 07 04 | 0A 0B 08 09 | 0F 0C 0D 0E.
//  3) fwd, k=3 -> output equals case 2 bit-for-bit; out_valid 4 cycles after accept.
//  4) k=0 -> out_state == in_state, out_valid 1 cycle after accept.
//     fwd k=2 -> row1 = 06 07 04 05.
//  5) Hold out_ready=0 for 5 cycles in DONE -> out_state stable, in_ready=0.
//     Then out_ready=1 -> next cycle in IDLE, out_state=0, in_ready=1.
//  6) Assert rst_n=0 during RUN (k=3) -> out_valid stays 0, out_state=0.
//     After release, in_ready=1 and a new k=1 job completes correctly.

Source files
------------

// File: rtl/msk_shiftrows_iter_if.sv
// Handshake bundle for the masked ShiftRows engine: input sharing channel and result channel.
interface msk_shiftrows_iter_if #(
  parameter int unsigned D  = 2,
  parameter int unsigned W  = 8,
  parameter int unsigned KW = 2
);
  localparam int unsigned SW = 16 * D * W;

  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_state;
  logic          in_inv;
  logic [KW-1:0] in_k;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;

  modport master (
    output in_valid, in_state, in_inv, in_k, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_inv, in_k, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/msk_shiftrows_iter.sv
// Masked Skinny ShiftRows^k / inverse engine: one row-rotation step per clock,
// every share permuted identically and independently.
module msk_shiftrows_iter #(
  parameter int unsigned D  = 2,
  parameter int unsigned W  = 8,
  parameter int unsigned KW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  msk_shiftrows_iter_if.slave  bus
);
  localparam int unsigned CW = D * W;
  localparam int unsigned SW = 16 * CW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic [SW-1:0] data_q, data_nxt;
  logic [SW-1:0] out_q;
  logic [KW-1:0] cnt_q, cnt_nxt;
  logic          inv_q, inv_nxt;
  logic          out_valid_q;

  // One ShiftRows step; cell c = 4r+j pulls from column (j-r) or (j+r) mod 4 of its row.
  function automatic logic [SW-1:0] shift_step(input logic [SW-1:0] s, input logic inv);
    logic [SW-1:0] r;
    int unsigned   src;
    r = '0;
    for (int unsigned c = 0; c < 16; c++) begin
      src = inv ? (c + (c >> 2)) : (c - (c >> 2));
      src = (c & 32'd12) | (src & 32'd3);
      r[(16-c)*CW-1 -: CW] = s[(16-src)*CW-1 -: CW];
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state_q;
    data_nxt  = data_q;
    cnt_nxt   = cnt_q;
    inv_nxt   = inv_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_nxt  = bus.in_state;
          inv_nxt   = bus.in_inv;
          cnt_nxt   = bus.in_k;
          state_nxt = (bus.in_k == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        data_nxt = shift_step(data_q, inv_q);
        cnt_nxt  = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) state_nxt = DONE;
      end
      DONE: begin
        // Wipe the sharing on hand-off so no share residue lingers in the register.
        if (bus.out_ready) begin
          data_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      data_q      <= data_nxt;
      cnt_q       <= cnt_nxt;
      inv_q       <= inv_nxt;
      // Intermediate rotations never reach the output; only the final state is exposed.
      out_q       <= (state_nxt == DONE) ? data_nxt : '0;
      out_valid_q <= (state_nxt == DONE);
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_q;

endmodule

// File: tb/tb_msk_shiftrows_iter.sv
// Scoreboard bench for msk_shiftrows_iter (d=2, W=8): direction, step count, latency,
// back-pressure and reset-abort scenarios.
module tb_msk_shiftrows_iter;
  localparam int unsigned SW = 256;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [SW-1:0] sb[$];

  always #5 clk = ~clk;

  msk_shiftrows_iter_if #(.D(2), .W(8), .KW(2)) ifc ();
  msk_shiftrows_iter #(.D(2), .W(8), .KW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] pat();
    logic [SW-1:0] v;
    for (int c = 0; c < 16; c++) v[(16-c)*16-1 -: 16] = {8'h80 | 8'(c), 8'(c)};
    return v;
  endfunction

  function automatic logic [SW-1:0] rnd_state();
    logic [SW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Closed form: k steps move each row by r*k columns at once.
  function automatic logic [SW-1:0] model(input logic [SW-1:0] st, input logic inv, input int k);
    logic [SW-1:0] v;
    int src;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) begin
        src = r*4 + (inv ? ((j + r*k) % 4) : ((j - r*k + 64) % 4));
        v[(16-(r*4+j))*16-1 -: 16] = st[(16-src)*16-1 -: 16];
      end
    return v;
  endfunction

  function automatic logic [SW-1:0] from_bytes(input logic [7:0] b [16]);
    logic [SW-1:0] v;
    for (int c = 0; c < 16; c++) v[(16-c)*16-1 -: 16] = {8'h80 | b[c], b[c]};
    return v;
  endfunction

  task automatic send(input logic [SW-1:0] st, input logic inv, input logic [1:0] k);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_state = st;
    ifc.in_inv   = inv;
    ifc.in_k     = k;
    sb.push_back(model(st, inv, int'(k)));
    while (!ifc.in_ready && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (!ifc.in_ready) begin
      errors++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", ifc.in_ready);
    end
    tick();
    ifc.in_valid = 1'b0;
    ifc.in_inv   = 1'($urandom);
    ifc.in_k     = 2'($urandom);
    ifc.in_state = rnd_state();
  endtask

  task automatic wait_out(input int lat0, output logic [SW-1:0] o, output int lat);
    lat = lat0;
    while (!ifc.out_valid && lat < 60) begin
      tick();
      lat++;
    end
    checks++;
    if (!ifc.out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", ifc.out_valid);
    end
    o = ifc.out_state;
  endtask

  task automatic release_out();
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_state !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b state=%h required 0 0 0",
               ifc.in_ready, ifc.out_valid, ifc.out_state);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", ifc.in_ready);
    end
  endtask

  task automatic test_fwd1();
    logic [SW-1:0] o, e;
    logic [7:0] b [16];
    int lat;
    b = '{8'h00,8'h01,8'h02,8'h03, 8'h07,8'h04,8'h05,8'h06,
          8'h0A,8'h0B,8'h08,8'h09, 8'h0D,8'h0E,8'h0F,8'h0C};
    send(pat(), 1'b0, 2'd1);
    wait_out(1, o, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 2) begin errors++; $display("FAIL fwd1_latency: %0d required 2", lat); end
    checks++;
    if (o !== e) begin errors++; $display("FAIL fwd1_model: %h required %h", o, e); end
    checks++;
    if (o !== from_bytes(b)) begin errors++; $display("FAIL fwd1_literal: %h required %h", o, from_bytes(b)); end
    release_out();
  endtask

  task automatic test_inv1_fwd3();
    logic [SW-1:0] o_inv, o, e;
    logic [7:0] b [16];
    int lat;
    b = '{8'h00,8'h01,8'h02,8'h03, 8'h05,8'h06,8'h07,8'h04,
          8'h0A,8'h0B,8'h08,8'h09, 8'h0F,8'h0C,8'h0D,8'h0E};
    send(pat(), 1'b1, 2'd1);
    wait_out(1, o_inv, lat);
    e = sb.pop_front();
    checks++;
    if (o_inv !== e) begin errors++; $display("FAIL inv1_model: %h required %h", o_inv, e); end
    checks++;
    if (o_inv !== from_bytes(b)) begin errors++; $display("FAIL inv1_literal: %h required %h", o_inv, from_bytes(b)); end
    release_out();
    // fwd k=3, with in_valid held high on garbage while RUN must ignore it
    send(pat(), 1'b0, 2'd3);
    ifc.in_valid = 1'b1;
    tick();
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.out_state !== '0) begin
      errors++;
      $display("FAIL run_outputs: ready=%b state=%h required 0 0", ifc.in_ready, ifc.out_state);
    end
    tick();
    ifc.in_valid = 1'b0;
    wait_out(3, o, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 4) begin errors++; $display("FAIL fwd3_latency: %0d required 4", lat); end
    checks++;
    if (o !== e) begin errors++; $display("FAIL fwd3_model: %h required %h", o, e); end
    checks++;
    if (o !== o_inv) begin errors++; $display("FAIL fwd3_eq_inv1: %h required %h", o, o_inv); end
    release_out();
  endtask

  task automatic test_k0_k2();
    logic [SW-1:0] o, e, p;
    logic [31:0] row1;
    int lat;
    p = pat();
    send(p, 1'b0, 2'd0);
    wait_out(1, o, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 1) begin errors++; $display("FAIL k0_latency: %0d required 1", lat); end
    checks++;
    if (o !== p || o !== e) begin errors++; $display("FAIL k0_identity: %h required %h", o, p); end
    release_out();
    send(p, 1'b0, 2'd2);
    wait_out(1, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e) begin errors++; $display("FAIL fwd2_model: %h required %h", o, e); end
    for (int j = 0; j < 4; j++) row1[31-8*j -: 8] = o[(16-(4+j))*16-9 -: 8];
    checks++;
    if (row1 !== 32'h06070405) begin errors++; $display("FAIL fwd2_row1: %h required 06070405", row1); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] o, e;
    int lat;
    send(rnd_state(), 1'b1, 2'd2);
    wait_out(1, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e) begin errors++; $display("FAIL bp_model: %h required %h", o, e); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifc.out_state !== e || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: state=%h valid=%b ready=%b required %h 1 0",
                 i, ifc.out_state, ifc.out_valid, ifc.in_ready, e);
      end
    end
    release_out();
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.out_state !== '0) begin
      errors++;
      $display("FAIL bp_release: ready=%b valid=%b state=%h required 1 0 0",
               ifc.in_ready, ifc.out_valid, ifc.out_state);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [SW-1:0] o, e;
    logic seen = 1'b0;
    int lat;
    send(pat(), 1'b0, 2'd3);
    void'(sb.pop_front());  // aborted job never produces output
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_state !== '0) begin
      errors++;
      $display("FAIL abort_in_reset: valid=%b state=%h required 0 0", ifc.out_valid, ifc.out_state);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ifc.out_valid !== 1'b0 || ifc.out_state !== '0) seen = 1'b1;
    end
    checks++;
    if (seen || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_after_release: residue=%b ready=%b required 0 1", seen, ifc.in_ready);
    end
    send(rnd_state(), 1'b0, 2'd1);
    wait_out(1, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e || lat != 2) begin
      errors++;
      $display("FAIL abort_next_job: %h lat=%0d required %h lat=2", o, lat, e);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] o, e;
    logic [1:0] k;
    int lat;
    for (int n = 0; n < 10; n++) begin
      k = 2'($urandom);
      send(rnd_state(), 1'($urandom), k);
      wait_out(1, o, lat);
      e = sb.pop_front();
      checks++;
      if (o !== e || lat != int'(k) + 1) begin
        errors++;
        $display("FAIL b2b_job%0d: %h lat=%0d required %h lat=%0d", n, o, lat, e, int'(k) + 1);
      end
      release_out();
    end
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_state  = '0;
    ifc.in_inv    = 1'b0;
    ifc.in_k      = '0;
    ifc.out_ready = 1'b0;
    test_reset();
    test_fwd1();
    test_inv1_fwd3();
    test_k0_k2();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
